mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port, word-wide data RAM between the instruction-fetch (IF) port and the load/store (LS) port.
- Per transaction: arbitrates, handles byte-lane alignment, tracks the fixed RAM read latency and returns a completion pulse.
- Sits between the fetch/memory pipeline stages and the RAM macro; drives a stall to the pipeline control unit.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; fixed at 32, 4 byte lanes.
- RAM_LAT, 1, cycles from ram_en_o to valid ram_rdata_i; legal range 1..4.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- if_req_i  in  1  fetch request; level; held stable until granted.
- if_addr_i  in  ADDR_W  fetch byte address; word-aligned.
- if_gnt_o  out  1  fetch granted this cycle.
- if_rvalid_o  out  1  one-cycle pulse; if_rdata_o valid.
- if_rdata_o  out  DATA_W  fetched word.
- ls_req_i  in  1  load/store request; level; held stable until granted.
- ls_we_i  in  1  1 = store.
- ls_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- ls_addr_i  in  ADDR_W  byte address.
- ls_wdata_i  in  DATA_W  store data, right-justified.
- ls_gnt_o  out  1  LS granted this cycle.
- ls_rvalid_o  out  1  one-cycle completion pulse, for loads and stores.
- ls_rdata_o  out  DATA_W  load data shifted right by the byte offset, zero-filled; 0 for stores.
- ls_err_o  out  1  misaligned access; valid with ls_rvalid_o.
- ram_en_o  out  1  RAM access strobe.
- ram_we_o  out  1  RAM write.
- ram_be_o  out  4  byte enables.
- ram_addr_o  out  ADDR_W  word address; bits [1:0] forced to 0.
- ram_wdata_o  out  DATA_W  lane-positioned write data.
- ram_rdata_i  in  DATA_W  RAM read data.
- stall_o  out  1  a request is pending and not granted this cycle.

Behaviour:
- Reset (rst_i low, asynchronous): all outputs 0, FSM IDLE, latency counter 0, round-robin pointer = LS. Any in-flight response is dropped and no rvalid is issued for it.
- FSM states: IDLE, WAIT.
  - IDLE: if any request, grant one; in the same cycle assert gnt and ram_en_o (except on error); load counter = RAM_LAT; go to WAIT.
  - WAIT: decrement the counter. When it reaches 0, pulse rvalid for the owner.
  - In that same rvalid cycle, a new grant is legal (back-to-back). Otherwise return to IDLE.
- Throughput: RAM_LAT = 1 gives one access per cycle. One outstanding access at a time.
- Arbitration (macro absent): LS has fixed priority over IF.
- Lane rules, with off = addr[1:0]:
  - Byte: be = 0001 << off.
  - Half: be = 0011 << off.
  - Word: be = 1111.
  - ram_wdata_o = ls_wdata_i << (8*off).
  - ls_rdata_o = ram_rdata_i >> (8*off), captured in the rvalid cycle.
- IF reads always use be = 1111 and ram_we_o = 0.
- Misaligned access (half with addr[0] = 1, or word with off != 0):
  - ls_gnt_o = 1, ram_en_o = 0.
  - After RAM_LAT cycles: ls_rvalid_o = 1, ls_err_o = 1, ls_rdata_o = 0.
- Store completion: ls_rvalid_o pulses RAM_LAT cycles after the grant.
- Registered outputs: rdata outputs hold their last value until the next rvalid.
- stall_o = (if_req_i & ~if_gnt_o) | (ls_req_i & ~ls_gnt_o), combinational.
- Request dropped before grant: no action, no error.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: when both ports request, grant alternates. A 1-bit pointer names the port granted next and flips to the other port after each contested grant. An uncontested grant does not move the pointer.
- Undefined: fixed LS priority; no pointer flop.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_B/SZ_H/SZ_W.
  - FSM state enum.
  - owner enum OWN_IF/OWN_LS.
  - RAM_LAT range constants.
  - byte-enable function.
- Sub-module mem_lane_align (combinational): be generation, write shift, read shift, misalign detect. Used once for stores and once for load return.

Test Plan:
- Reset mid-WAIT: grant an LS load, then pull rst_i low -> all outputs 0 immediately; no ls_rvalid_o after release.
- LS sb, addr 0x103, wdata 0xA5 -> ram_be_o = 1000, ram_addr_o = 0x100, ram_wdata_o = 0xA5000000, ls_rvalid_o 1 cycle later.
- LS lh, addr 0x202, ram_rdata_i = 0xBEEF1234 -> ls_rdata_o = 0x0000BEEF.
- LS lw, addr 0x006 -> ram_en_o never asserted; ls_err_o = 1 with ls_rvalid_o; ls_rdata_o = 0.
- IF and LS both requesting for 4 cycles, RAM_LAT = 1:
  - Macro absent: LS granted every cycle, stall_o = 1.
  - Macro defined: grants alternate LS, IF, LS, IF.
- RAM_LAT = 3, back-to-back IF reads -> grants at cycles 0, 3, 6; if_rvalid_o at 3, 6, 9.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the IF/LS data-RAM arbiter.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int RAM_LAT_MIN = 1;
    localparam int RAM_LAT_MAX = 4;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;
    typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;

    // Size code 3 falls into the word case on purpose.
    function automatic logic [3:0] be_calc(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request, response and RAM-side bundle of the memory arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              ls_req_i;
    logic              ls_we_i;
    logic [1:0]        ls_size_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [DATA_W-1:0] ls_wdata_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [DATA_W-1:0] ls_rdata_o;
    logic              ls_err_o;
    logic              ram_en_o;
    logic              ram_we_o;
    logic [3:0]        ram_be_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i;
    logic              stall_o;

    modport slave (
        input  if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i, ram_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
               ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o, stall_o
    );

    modport master (
        output if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i, ram_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
               ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o, stall_o
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: enables, write/read shifts and misalignment detect.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        off_i,
    input  logic [1:0]        size_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [3:0]        be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              misalign_o
);
    logic [4:0] shamt_s;

    assign shamt_s = {off_i, 3'b000};

    // Lane enables, shifted data and natural-alignment check.
    always_comb begin
        be_o    = be_calc(size_i, off_i);
        wdata_o = wdata_i << shamt_s;
        rdata_o = rdata_i >> shamt_s;
        case (size_i)
            SZ_B:    misalign_o = 1'b0;
            SZ_H:    misalign_o = off_i[0];
            default: misalign_o = (off_i != 2'b00);
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port data-RAM arbiter for the fetch and load/store ports.
// Define MEM_ARB_RR_EN for round-robin on contention (default: LS priority).
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus
);
    localparam int LAT_C = (RAM_LAT < RAM_LAT_MIN) ? RAM_LAT_MIN :
                           (RAM_LAT > RAM_LAT_MAX) ? RAM_LAT_MAX : RAM_LAT;
    localparam logic [2:0] LAT_LD = 3'(LAT_C);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [1:0]        off_q, off_d, size_q, size_d;
    logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
    logic              done_s, free_s, pick_ls_s, gnt_if_s, gnt_ls_s, gnt_s;
    logic              if_rvalid_s, ls_rvalid_s, req_mis_s, ret_mis_s;
    logic [3:0]        req_be_s, ret_be_s;
    logic [DATA_W-1:0] req_wdata_s, req_rdata_s, ret_wdata_s, ret_rdata_s, ls_ret_s;
    logic              unused_s;

`ifdef MEM_ARB_RR_EN
    owner_e            ptr_q, ptr_d;
`endif

    mem_lane_align #(.DATA_W(DATA_W)) u_req_align (
        .off_i(bus.ls_addr_i[1:0]), .size_i(bus.ls_size_i), .wdata_i(bus.ls_wdata_i),
        .rdata_i({DATA_W{1'b0}}), .be_o(req_be_s), .wdata_o(req_wdata_s),
        .rdata_o(req_rdata_s), .misalign_o(req_mis_s)
    );

    mem_lane_align #(.DATA_W(DATA_W)) u_ret_align (
        .off_i(off_q), .size_i(size_q), .wdata_i({DATA_W{1'b0}}),
        .rdata_i(bus.ram_rdata_i), .be_o(ret_be_s), .wdata_o(ret_wdata_s),
        .rdata_o(ret_rdata_s), .misalign_o(ret_mis_s)
    );

    // Grant decision: a slot is free in IDLE or in the cycle a response completes.
    always_comb begin
        done_s = (state_q == ST_WAIT) && (cnt_q == 3'd1);
        free_s = rst_i && ((state_q == ST_IDLE) || done_s);
`ifdef MEM_ARB_RR_EN
        pick_ls_s = bus.ls_req_i && (!bus.if_req_i || (ptr_q == OWN_LS));
`else
        pick_ls_s = bus.ls_req_i;
`endif
        gnt_ls_s = free_s && pick_ls_s;
        gnt_if_s = free_s && bus.if_req_i && !pick_ls_s;
        gnt_s    = gnt_ls_s || gnt_if_s;
    end

    // RAM strobe; a misaligned LS grant is accepted but never reaches the RAM.
    always_comb begin
        bus.ram_en_o    = 1'b0;
        bus.ram_we_o    = 1'b0;
        bus.ram_be_o    = 4'b0000;
        bus.ram_addr_o  = {ADDR_W{1'b0}};
        bus.ram_wdata_o = {DATA_W{1'b0}};
        if (gnt_ls_s && !req_mis_s) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_we_o    = bus.ls_we_i;
            bus.ram_be_o    = req_be_s;
            bus.ram_addr_o  = {bus.ls_addr_i[ADDR_W-1:2], 2'b00};
            bus.ram_wdata_o = bus.ls_we_i ? req_wdata_s : {DATA_W{1'b0}};
        end else if (gnt_if_s) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_be_o    = 4'b1111;
            bus.ram_addr_o  = {bus.if_addr_i[ADDR_W-1:2], 2'b00};
        end else begin
            bus.ram_en_o    = 1'b0;
        end
    end

    // FSM next state and per-transaction context captured at grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_LD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (done_s && gnt_s) begin
                    cnt_d = LAT_LD;
                end else if (done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
        if (gnt_s) begin
            owner_d = gnt_ls_s ? OWN_LS : OWN_IF;
            we_d    = gnt_ls_s && bus.ls_we_i;
            off_d   = gnt_ls_s ? bus.ls_addr_i[1:0] : 2'b00;
            size_d  = gnt_ls_s ? bus.ls_size_i : SZ_W;
        end else begin
            owner_d = owner_q;
            we_d    = we_q;
            off_d   = off_q;
            size_d  = size_q;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Pointer moves only when both ports competed for the slot.
    always_comb begin
        if (gnt_s && bus.if_req_i && bus.ls_req_i) begin
            ptr_d = gnt_ls_s ? OWN_IF : OWN_LS;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q <= OWN_LS;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign if_rvalid_s = done_s && (owner_q == OWN_IF);
    assign ls_rvalid_s = done_s && (owner_q == OWN_LS);
    assign ls_ret_s    = (we_q || ret_mis_s) ? {DATA_W{1'b0}} : ret_rdata_s;

    assign bus.if_gnt_o    = gnt_if_s;
    assign bus.ls_gnt_o    = gnt_ls_s;
    assign bus.stall_o     = rst_i && ((bus.if_req_i && !gnt_if_s) || (bus.ls_req_i && !gnt_ls_s));
    assign bus.if_rvalid_o = if_rvalid_s;
    assign bus.ls_rvalid_o = ls_rvalid_s;
    assign bus.ls_err_o    = ls_rvalid_s && ret_mis_s;
    assign bus.if_rdata_o  = if_rvalid_s ? bus.ram_rdata_i : if_rdata_q;
    assign bus.ls_rdata_o  = ls_rvalid_s ? ls_ret_s : ls_rdata_q;

    assign unused_s = ^{req_rdata_s, ret_be_s, ret_wdata_s, bus.if_addr_i[1:0]};

    // State, counter, context and held read data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            off_q      <= 2'b00;
            size_q     <= SZ_W;
            if_rdata_q <= {DATA_W{1'b0}};
            ls_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            off_q      <= off_d;
            size_q     <= size_d;
            if_rdata_q <= bus.if_rdata_o;
            ls_rdata_q <= bus.ls_rdata_o;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases, then random traffic against a transaction-level model.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT))  dut  (.clk_i(clk), .rst_i(rst_n), .bus(bus));
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT3)) dut3 (.clk_i(clk), .rst_i(rst_n), .bus(bus3));

    // RAM macro models: byte-enabled writes, reads delivered after the fixed latency.
    logic [31:0] ram_mem [1024] = '{default: 32'h0};
    logic [31:0] pipe    [4]    = '{default: 32'h0};
    logic [31:0] pipe3   [4]    = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus.ram_en_o && bus.ram_we_o)
            for (int b = 0; b < 4; b++)
                if (bus.ram_be_o[b]) ram_mem[bus.ram_addr_o[11:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
        pipe[0]  <= (bus.ram_en_o && !bus.ram_we_o) ? ram_mem[bus.ram_addr_o[11:2]] : $urandom;
        pipe3[0] <= bus3.ram_en_o ? (bus3.ram_addr_o ^ 32'h5A5A0000) : $urandom;
        for (int i = 1; i < 4; i++) begin
            pipe[i]  <= pipe[i-1];
            pipe3[i] <= pipe3[i-1];
        end
    end
    assign bus.ram_rdata_i  = pipe[LAT-1];
    assign bus3.ram_rdata_i = pipe3[LAT3-1];

    // Reference model state
    int          checks = 0, errors = 0, cyc = 0, next_free = 0, resp_due = 0;
    bit          resp_pend = 1'b0, resp_err = 1'b0, last_g_if = 1'b0, last_g_ls = 1'b0;
    owner_e      resp_own = OWN_IF, ref_ptr = OWN_LS;
    logic [31:0] resp_data = 32'h0, exp_if_hold = 32'h0, exp_ls_hold = 32'h0;
    logic [31:0] ref_mem [1024] = '{default: 32'h0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        resp_pend = 1'b0; next_free = 0; ref_ptr = OWN_LS;
        exp_if_hold = 32'h0; exp_ls_hold = 32'h0;
    endtask

    // One cycle of the model, evaluated at the falling edge.
    task automatic sample();
        bit e_ifv, e_lsv, e_err, g_if, g_ls, mis;
        int n, idx;
        logic [1:0] off;
        logic [3:0] be_e;
        logic [31:0] wsh;
        @(negedge clk);
        e_ifv = 1'b0; e_lsv = 1'b0; e_err = 1'b0;
        if (resp_pend && resp_due == cyc) begin
            resp_pend = 1'b0;
            if (resp_own == OWN_IF) begin e_ifv = 1'b1; exp_if_hold = resp_data; end
            else begin e_lsv = 1'b1; e_err = resp_err; exp_ls_hold = resp_data; end
        end
        chk("if_rvalid", 32'(bus.if_rvalid_o), 32'(e_ifv));
        chk("ls_rvalid", 32'(bus.ls_rvalid_o), 32'(e_lsv));
        chk("ls_err", 32'(bus.ls_err_o), 32'(e_err));
        chk("if_rdata", bus.if_rdata_o, exp_if_hold);
        chk("ls_rdata", bus.ls_rdata_o, exp_ls_hold);
        g_if = 1'b0; g_ls = 1'b0;
        if (rst_n && cyc >= next_free) begin
            if (bus.ls_req_i && bus.if_req_i) begin
`ifdef MEM_ARB_RR_EN
                g_ls = (ref_ptr == OWN_LS); g_if = !g_ls; ref_ptr = g_ls ? OWN_IF : OWN_LS;
`else
                g_ls = 1'b1;
`endif
            end else begin
                g_ls = bus.ls_req_i; g_if = bus.if_req_i;
            end
        end
        chk("if_gnt", 32'(bus.if_gnt_o), 32'(g_if));
        chk("ls_gnt", 32'(bus.ls_gnt_o), 32'(g_ls));
        chk("stall", 32'(bus.stall_o), 32'(rst_n && ((bus.if_req_i && !g_if) || (bus.ls_req_i && !g_ls))));
        last_g_if = g_if; last_g_ls = g_ls;
        if (g_ls) begin
            off  = bus.ls_addr_i[1:0];
            idx  = int'(bus.ls_addr_i[11:2]);
            n    = (bus.ls_size_i == 2'd0) ? 1 : (bus.ls_size_i == 2'd1) ? 2 : 4;
            mis  = (n == 2 && off[0]) || (n == 4 && off != 2'd0);
            be_e = 4'(((1 << n) - 1) << off);
            wsh  = bus.ls_wdata_i << (8 * off);
            chk("ls_ram_en", 32'(bus.ram_en_o), 32'(!mis));
            if (!mis) begin
                chk("ls_ram_we", 32'(bus.ram_we_o), 32'(bus.ls_we_i));
                chk("ls_ram_be", 32'(bus.ram_be_o), 32'(be_e));
                chk("ls_ram_addr", bus.ram_addr_o, bus.ls_addr_i & 32'hFFFF_FFFC);
                if (bus.ls_we_i) chk("ls_ram_wdata", bus.ram_wdata_o, wsh);
            end
            resp_own = OWN_LS; resp_err = mis;
            resp_data = (mis || bus.ls_we_i) ? 32'h0 : (ref_mem[idx] >> (8 * off));
            if (!mis && bus.ls_we_i)
                for (int b = 0; b < 4; b++)
                    if (be_e[b]) ref_mem[idx][8*b +: 8] = wsh[8*b +: 8];
            resp_pend = 1'b1; resp_due = cyc + LAT; next_free = cyc + LAT;
        end else if (g_if) begin
            idx = int'(bus.if_addr_i[11:2]);
            chk("if_ram_en", 32'(bus.ram_en_o), 32'h1);
            chk("if_ram_we", 32'(bus.ram_we_o), 32'h0);
            chk("if_ram_be", 32'(bus.ram_be_o), 32'hF);
            chk("if_ram_addr", bus.ram_addr_o, bus.if_addr_i & 32'hFFFF_FFFC);
            resp_own = OWN_IF; resp_err = 1'b0; resp_data = ref_mem[idx];
            resp_pend = 1'b1; resp_due = cyc + LAT; next_free = cyc + LAT;
        end else begin
            chk("idle_ram_en", 32'(bus.ram_en_o), 32'h0);
        end
    endtask

    // Advance past the rising edge and retire granted requests.
    task automatic next();
        @(posedge clk); #1;
        cyc++;
        if (last_g_if) bus.if_req_i = 1'b0;
        if (last_g_ls) bus.ls_req_i = 1'b0;
        last_g_if = 1'b0; last_g_ls = 1'b0;
    endtask

    task automatic set_ls(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        bus.ls_req_i = 1'b1; bus.ls_we_i = we; bus.ls_size_i = sz; bus.ls_addr_i = a; bus.ls_wdata_i = wd;
    endtask

    task automatic set_if(input logic [31:0] a);
        bus.if_req_i = 1'b1; bus.if_addr_i = a;
    endtask

    initial begin
        bus.if_req_i = 1'b0; bus.if_addr_i = 32'h0; bus.ls_req_i = 1'b0; bus.ls_we_i = 1'b0;
        bus.ls_size_i = 2'd0; bus.ls_addr_i = 32'h0; bus.ls_wdata_i = 32'h0;
        bus3.if_req_i = 1'b0; bus3.if_addr_i = 32'h0; bus3.ls_req_i = 1'b0; bus3.ls_we_i = 1'b0;
        bus3.ls_size_i = 2'd0; bus3.ls_addr_i = 32'h0; bus3.ls_wdata_i = 32'h0;

        sample(); next();
        rst_n = 1'b1;

        // sb 0x103
        set_ls(1'b1, SZ_B, 32'h103, 32'hA5);
        sample();
        chk("sb_be", 32'(bus.ram_be_o), 32'h8);
        chk("sb_addr", bus.ram_addr_o, 32'h100);
        chk("sb_wdata", bus.ram_wdata_o, 32'hA500_0000);
        next(); sample();
        chk("sb_rvalid", 32'(bus.ls_rvalid_o), 32'h1);
        next();

        // sw 0x200 then lh 0x202
        set_ls(1'b1, SZ_W, 32'h200, 32'hBEEF_1234);
        sample(); next();
        set_ls(1'b0, SZ_H, 32'h202, 32'h0);
        sample(); next(); sample();
        chk("lh_rdata", bus.ls_rdata_o, 32'h0000_BEEF);
        next();

        // misaligned lw 0x006
        set_ls(1'b0, SZ_W, 32'h006, 32'h0);
        sample();
        chk("mis_ram_en", 32'(bus.ram_en_o), 32'h0);
        next(); sample();
        chk("mis_err", 32'(bus.ls_err_o), 32'h1);
        chk("mis_rdata", bus.ls_rdata_o, 32'h0);
        next();

        // both ports contending for four cycles
        for (int k = 0; k < 4; k++) begin
            set_if(32'h40 + 32'(4 * k));
            if (!bus.ls_req_i) set_ls(1'b0, SZ_W, 32'h200, 32'h0);
            sample();
            chk("contend_stall", 32'(bus.stall_o), 32'h1);
`ifdef MEM_ARB_RR_EN
            chk("contend_ls_gnt", 32'(bus.ls_gnt_o), 32'((k % 2) == 0));
`else
            chk("contend_ls_gnt", 32'(bus.ls_gnt_o), 32'h1);
`endif
            next();
        end
        bus.if_req_i = 1'b0; bus.ls_req_i = 1'b0;
        sample(); next(); sample(); next();

        // reset while a load is in flight
        set_ls(1'b0, SZ_W, 32'h200, 32'h0);
        sample(); next();
        rst_n = 1'b0; #1;
        chk("rst_ls_rvalid", 32'(bus.ls_rvalid_o), 32'h0);
        chk("rst_ls_rdata", bus.ls_rdata_o, 32'h0);
        chk("rst_if_rdata", bus.if_rdata_o, 32'h0);
        chk("rst_ram", {bus.ram_en_o, bus.ram_we_o, bus.ram_be_o}, 32'h0);
        chk("rst_ram_addr", bus.ram_addr_o, 32'h0);
        chk("rst_gnt_stall", {bus.if_gnt_o, bus.ls_gnt_o, bus.stall_o, bus.if_rvalid_o, bus.ls_err_o}, 32'h0);
        model_reset();
        sample(); next();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin sample(); next(); end

        // RAM_LAT = 3 back-to-back fetches on the second instance
        bus3.if_req_i = 1'b1; bus3.if_addr_i = 32'h80;
        for (int k = 0; k < 11; k++) begin
            sample();
            chk("lat3_gnt", 32'(bus3.if_gnt_o), 32'(k == 0 || k == 3 || k == 6));
            chk("lat3_rvalid", 32'(bus3.if_rvalid_o), 32'(k == 3 || k == 6 || k == 9));
            if (k == 3 || k == 6 || k == 9)
                chk("lat3_rdata", bus3.if_rdata_o, (32'h80 + 32'(4 * (k / 3 - 1))) ^ 32'h5A5A0000);
            next();
            if (k == 0 || k == 3) bus3.if_addr_i = bus3.if_addr_i + 32'h4;
            if (k == 6) bus3.if_req_i = 1'b0;
        end

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if (!bus.ls_req_i) begin
                if ($urandom_range(0, 2) == 0)
                    set_ls(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 255)), $urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                bus.ls_req_i = 1'b0;
            end
            if (!bus.if_req_i) begin
                if ($urandom_range(0, 2) == 0) set_if(32'($urandom_range(0, 63)) << 2);
            end else if ($urandom_range(0, 15) == 0) begin
                bus.if_req_i = 1'b0;
            end
            sample(); next();
        end
        bus.if_req_i = 1'b0; bus.ls_req_i = 1'b0;
        for (int k = 0; k < 4; k++) begin sample(); next(); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
